// File: rtl/xillyusb_speedtest_engine.sv
// USB3 throughput test engine: deterministic pattern source, pattern-checking sink,
// word/error/rate counters and status LEDs on the XillyUSB 32-bit stream ports.
//   state  | meaning
//   IDLE   | read stream closed or not yet opened; empty=1
//   RUN    | delivering pattern words; empty=0
//   DONE   | TX_LEN words delivered; empty=1, eof=1 until close
module xillyusb_speedtest_engine #(
  parameter logic [31:0] SEED        = 32'h0000_0001,
  parameter int unsigned RATE_WINDOW = 125_000_000,
  parameter int unsigned TX_LEN      = 0
) (
  input  logic        bus_clk,
  input  logic        srst,
  input  logic        mode_lfsr,
  input  logic        user_r_read_32_open,
  input  logic        user_r_read_32_rden,
  output logic [31:0] user_r_read_32_data,
  output logic        user_r_read_32_empty,
  output logic        user_r_read_32_eof,
  input  logic        user_w_write_32_open,
  input  logic        user_w_write_32_wren,
  input  logic [31:0] user_w_write_32_data,
  output logic        user_w_write_32_full,
  output logic [31:0] tx_words,
  output logic [31:0] rx_words,
  output logic [15:0] err_count,
  output logic [31:0] first_err_data,
  output logic [31:0] rx_rate,
  output logic [7:0]  status_led
);

  localparam int unsigned     WIN_W     = $clog2(RATE_WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(RATE_WINDOW - 1);
  localparam logic [31:0]     LFSR_SEED = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0]     TX_LEN_W  = 32'(TX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} src_state_t;

  function automatic logic [31:0] next_pat(input logic [31:0] p, input logic lfsr);
    if (lfsr) return {p[30:0], p[31] ^ p[21] ^ p[1] ^ p[0]};
    else      return p + 32'd1;
  endfunction

  // An all-zero LFSR would lock up, so LFSR mode never starts from zero.
  function automatic logic [31:0] seed_for(input logic lfsr);
    return lfsr ? LFSR_SEED : SEED;
  endfunction

  src_state_t  src_state_q;
  logic        rd_open_q, wr_open_q;
  logic [31:0] gen_q, rdata_q, tx_words_q;
  logic        src_lfsr_q, empty_q, eof_q, done_q;
  logic [31:0] exp_q, rx_words_q, first_err_q;
  logic [15:0] err_q;
  logic        snk_lfsr_q, err_seen_q, err_nz_q;
  logic [WIN_W-1:0] win_q;
  logic [31:0] acc_q, rate_q;
  logic        hb_q;

  logic        rd_rise, rd_fall, wr_rise, wr_accept, pat_err;
  logic [31:0] gen_d, tx_words_d, exp_d, acc_d;

  assign rd_rise    = user_r_read_32_open & ~rd_open_q;
  assign rd_fall    = ~user_r_read_32_open & rd_open_q;
  assign wr_rise    = user_w_write_32_open & ~wr_open_q;
  assign wr_accept  = user_w_write_32_wren & user_w_write_32_open & wr_open_q;
  assign pat_err    = user_w_write_32_data != exp_q;
  assign gen_d      = next_pat(gen_q, src_lfsr_q);
  assign tx_words_d = tx_words_q + 32'd1;
  assign exp_d      = next_pat(user_w_write_32_data, snk_lfsr_q);
  assign acc_d      = acc_q + 32'(wr_accept);

  always_ff @(posedge bus_clk) begin
    if (srst) begin
      src_state_q <= S_IDLE;
      rd_open_q   <= 1'b0;
      gen_q       <= SEED;
      src_lfsr_q  <= 1'b0;
      rdata_q     <= 32'd0;
      tx_words_q  <= 32'd0;
      empty_q     <= 1'b1;
      eof_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_open_q <= user_r_read_32_open;
      if (rd_fall) begin
        src_state_q <= S_IDLE;
        empty_q     <= 1'b1;
        eof_q       <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        case (src_state_q)
          S_IDLE: begin
            if (rd_rise) begin
              gen_q       <= seed_for(mode_lfsr);
              src_lfsr_q  <= mode_lfsr;
              tx_words_q  <= 32'd0;
              empty_q     <= 1'b0;
              src_state_q <= S_RUN;
            end
          end
          S_RUN: begin
            if (user_r_read_32_rden) begin
              rdata_q    <= gen_q;
              gen_q      <= gen_d;
              tx_words_q <= tx_words_d;
              if (TX_LEN_W != 32'd0 && tx_words_d == TX_LEN_W) begin
                empty_q     <= 1'b1;
                eof_q       <= 1'b1;
                done_q      <= 1'b1;
                src_state_q <= S_DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Checker resynchronises on every received word: the next expected value
  // derives from the data actually seen, not from the previous expectation.
  always_ff @(posedge bus_clk) begin
    if (srst) begin
      wr_open_q   <= 1'b0;
      exp_q       <= SEED;
      snk_lfsr_q  <= 1'b0;
      rx_words_q  <= 32'd0;
      err_q       <= 16'd0;
      err_nz_q    <= 1'b0;
      err_seen_q  <= 1'b0;
      first_err_q <= 32'd0;
    end else begin
      wr_open_q <= user_w_write_32_open;
      if (wr_rise) begin
        exp_q      <= seed_for(mode_lfsr);
        snk_lfsr_q <= mode_lfsr;
        rx_words_q <= 32'd0;
        err_q      <= 16'd0;
        err_nz_q   <= 1'b0;
        err_seen_q <= 1'b0;
      end else if (wr_accept) begin
        rx_words_q <= rx_words_q + 32'd1;
        exp_q      <= exp_d;
        if (pat_err) begin
          err_nz_q <= 1'b1;
          if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
          if (!err_seen_q) begin
            first_err_q <= user_w_write_32_data;
            err_seen_q  <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (srst) begin
      win_q  <= '0;
      acc_q  <= 32'd0;
      rate_q <= 32'd0;
      hb_q   <= 1'b0;
    end else if (win_q == WIN_LAST) begin
      win_q  <= '0;
      acc_q  <= 32'd0;
      rate_q <= acc_d;
      hb_q   <= ~hb_q;
    end else begin
      win_q <= win_q + WIN_W'(1);
      acc_q <= acc_d;
    end
  end

  assign user_r_read_32_data  = rdata_q;
  assign user_r_read_32_empty = empty_q;
  assign user_r_read_32_eof   = eof_q;
  assign user_w_write_32_full = 1'b0;
  assign tx_words             = tx_words_q;
  assign rx_words             = rx_words_q;
  assign err_count            = err_q;
  assign first_err_data       = first_err_q;
  assign rx_rate              = rate_q;
  assign status_led           = {hb_q, 3'b000, err_nz_q, done_q, wr_open_q, rd_open_q};

endmodule
